// File: rtl/gpio_in_conditioner_if.sv
// Pad-side bundle for gpio_in_conditioner; the glitch-count port pair exists only with GPIO_IN_GLITCH_CNT_EN.
// master drives raw pads and configuration, slave (the conditioner) returns clean levels and pulses.
interface gpio_in_conditioner_if #(
  parameter int GPIO_NUM = 2,
  parameter int CNT_W    = 8
) ();
  logic [GPIO_NUM-1:0] gpio_i;
  logic [GPIO_NUM-1:0] filt_en_i;
  logic [CNT_W-1:0]    debounce_cycles_i;
  logic [GPIO_NUM-1:0] gpio_o;
  logic [GPIO_NUM-1:0] rise_o;
  logic [GPIO_NUM-1:0] fall_o;
`ifdef GPIO_IN_GLITCH_CNT_EN
  logic                  glitch_clr_i;
  logic [GPIO_NUM*8-1:0] glitch_cnt_o;

  modport master (
    output gpio_i, filt_en_i, debounce_cycles_i, glitch_clr_i,
    input  gpio_o, rise_o, fall_o, glitch_cnt_o
  );
  modport slave (
    input  gpio_i, filt_en_i, debounce_cycles_i, glitch_clr_i,
    output gpio_o, rise_o, fall_o, glitch_cnt_o
  );
`else
  modport master (
    output gpio_i, filt_en_i, debounce_cycles_i,
    input  gpio_o, rise_o, fall_o
  );
  modport slave (
    input  gpio_i, filt_en_i, debounce_cycles_i,
    output gpio_o, rise_o, fall_o
  );
`endif
endinterface

// File: rtl/gpio_in_conditioner.sv
// Per-pin synchronizer + debounce FSM with registered rise/fall pulses; GPIO_IN_GLITCH_CNT_EN adds per-channel glitch counters.
// Latency SYNC_STAGES+Neff-1 edges from a steady pin to gpio_o; no backpressure, every cycle is accepted.
module gpio_in_conditioner #(
  parameter int GPIO_NUM    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  gpio_in_conditioner_if.slave  bus
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_e;

  localparam logic [CNT_W:0]   NEFF_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Threshold is sampled live; a zero threshold behaves as one.
  logic [CNT_W:0] neff;
  always_comb begin
    neff = {1'b0, bus.debounce_cycles_i};
    if (bus.debounce_cycles_i == '0) neff = NEFF_ONE;
  end

  logic [GPIO_NUM-1:0] lvl_vec, rise_vec, fall_vec;

`ifdef GPIO_IN_GLITCH_CNT_EN
  logic [GPIO_NUM*8-1:0] gcnt_vec;
  assign bus.glitch_cnt_o = gcnt_vec;
`endif

  for (genvar g = 0; g < GPIO_NUM; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   lvl_q, rise_q, fall_q;
    logic                   s, filt;
    logic [CNT_W:0]         cnt_inc;
    logic                   cnt_done;

    assign s        = sync_q[SYNC_STAGES-1];
    assign filt     = bus.filt_en_i[g];
    assign cnt_inc  = {1'b0, cnt_q} + NEFF_ONE;
    assign cnt_done = (cnt_inc >= neff);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], bus.gpio_i[g]};
    end

    // lvl_q tracks (state in STABLE_HI/CHK_LO); pulses are set only on edges that flip it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (!filt) begin
          state_q <= s ? STABLE_HI : STABLE_LO;
          cnt_q   <= '0;
          lvl_q   <= s;
          rise_q  <= s & ~lvl_q;
          fall_q  <= ~s & lvl_q;
        end else begin
          case (state_q)
            STABLE_LO: begin
              if (s) begin
                if (neff == NEFF_ONE) begin
                  state_q <= STABLE_HI;
                  lvl_q   <= 1'b1;
                  rise_q  <= 1'b1;
                end else begin
                  state_q <= CHK_HI;
                  cnt_q   <= CNT_ONE;
                end
              end
            end
            CHK_HI: begin
              if (!s) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
              end else if (cnt_done) begin
                state_q <= STABLE_HI;
                cnt_q   <= '0;
                lvl_q   <= 1'b1;
                rise_q  <= 1'b1;
              end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            STABLE_HI: begin
              if (!s) begin
                if (neff == NEFF_ONE) begin
                  state_q <= STABLE_LO;
                  lvl_q   <= 1'b0;
                  fall_q  <= 1'b1;
                end else begin
                  state_q <= CHK_LO;
                  cnt_q   <= CNT_ONE;
                end
              end
            end
            CHK_LO: begin
              if (s) begin
                state_q <= STABLE_HI;
                cnt_q   <= '0;
              end else if (cnt_done) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                fall_q  <= 1'b1;
              end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            default: begin
              state_q <= STABLE_LO;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end

    assign lvl_vec[g]  = lvl_q;
    assign rise_vec[g] = rise_q;
    assign fall_vec[g] = fall_q;

`ifdef GPIO_IN_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] gcnt_q;

    assign abort = filt && (((state_q == CHK_HI) && !s) || ((state_q == CHK_LO) && s));

    // Clear wins over a same-cycle abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                        gcnt_q <= '0;
      else if (bus.glitch_clr_i)          gcnt_q <= '0;
      else if (abort && gcnt_q != 8'hFF)  gcnt_q <= gcnt_q + 8'd1;
    end

    assign gcnt_vec[g*8 +: 8] = gcnt_q;
`endif
  end

  assign bus.gpio_o = lvl_vec;
  assign bus.rise_o = rise_vec;
  assign bus.fall_o = fall_vec;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Randomized scoreboard bench for gpio_in_conditioner; the reference model is a sample delay line plus run-length debounce.
module tb_gpio_in_conditioner;
  localparam int G  = 2;
  localparam int S  = 2;
  localparam int CW = 8;

  typedef struct packed {
    logic [G-1:0]   lvl;
    logic [G-1:0]   rise;
    logic [G-1:0]   fall;
    logic [G*8-1:0] gc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.GPIO_NUM(G), .CNT_W(CW)) bus ();

  gpio_in_conditioner #(.GPIO_NUM(G), .SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int   checks = 0;
  int   errors = 0;
  bit   started = 1'b0;
  bit   clr = 1'b0;
  exp_t sbq[$];

  // Model state: raw samples delayed by S edges, accepted level, run of differing samples, glitch counts.
  logic [G-1:0] hist[$];
  bit           lvl[G];
  int           run[G];
  int           gc[G];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < S; k++) hist.push_back('0);
    for (int i = 0; i < G; i++) begin
      lvl[i] = 1'b0;
      run[i] = 0;
      gc[i]  = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    logic [G-1:0] s;
    int neff;
    s = hist.pop_front();
    hist.push_back(bus.gpio_i);
    neff = (bus.debounce_cycles_i == 0) ? 1 : int'(bus.debounce_cycles_i);
    e = '0;
    for (int i = 0; i < G; i++) begin
      bit prev;
      bit glitch;
      prev = lvl[i];
      glitch = 1'b0;
      if (!bus.filt_en_i[i]) begin
        lvl[i] = s[i];
        run[i] = 0;
      end else if (s[i] != lvl[i]) begin
        run[i]++;
        if (run[i] >= neff) begin
          lvl[i] = s[i];
          run[i] = 0;
        end
      end else begin
        glitch = (run[i] > 0);
        run[i] = 0;
      end
      if (clr) gc[i] = 0;
      else if (glitch && gc[i] < 255) gc[i]++;
      e.lvl[i]  = lvl[i];
      e.rise[i] = lvl[i] & ~prev;
      e.fall[i] = ~lvl[i] & prev;
      e.gc[i*8 +: 8] = 8'(gc[i]);
    end
  endtask

  // Inputs are already set for the coming rising edge; push what the outputs must be after it.
  task automatic tick();
    exp_t e;
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else begin
      model_step(e);
    end
`ifdef GPIO_IN_GLITCH_CNT_EN
    bus.glitch_clr_i = clr;
`endif
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input logic [G-1:0] g, input int n);
    bus.gpio_i = g;
    for (int k = 0; k < n; k++) tick();
  endtask

  always begin
    @(posedge clk);
    #2;
    if (started) begin
      if (sbq.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("gpio_o", 64'(bus.gpio_o), 64'(e.lvl));
        check("rise_o", 64'(bus.rise_o), 64'(e.rise));
        check("fall_o", 64'(bus.fall_o), 64'(e.fall));
        check("rise_fall_excl", 64'(bus.rise_o & bus.fall_o), 64'd0);
`ifdef GPIO_IN_GLITCH_CNT_EN
        check("glitch_cnt_o", 64'(bus.glitch_cnt_o), 64'(e.gc));
`endif
      end
    end
  end

  initial begin
    bus.gpio_i = '0;
    bus.filt_en_i = '1;
    bus.debounce_cycles_i = 8'd4;
`ifdef GPIO_IN_GLITCH_CNT_EN
    bus.glitch_clr_i = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    started = 1'b1;

    // Reset held, then idle inputs for 100 cycles.
    hold('0, 3);
    rst_n = 1'b1;
    hold('0, 100);

    // Debounced rise on channel 0 with threshold 4; channel 1 stays low.
    hold(2'b01, 12);
    hold(2'b00, 12);

    // Three-cycle pulse is shorter than the threshold: rejected as a glitch.
    hold(2'b01, 3);
    hold(2'b00, 10);

    // Bypass: a one-cycle pulse on channel 1 passes straight through.
    bus.filt_en_i = '0;
    hold(2'b10, 1);
    hold(2'b00, 6);
    bus.filt_en_i = '1;

    // Thresholds 0 and 1 behave the same.
    bus.debounce_cycles_i = 8'd0;
    hold(2'b01, 6);
    hold(2'b00, 6);
    bus.debounce_cycles_i = 8'd1;
    hold(2'b01, 6);
    hold(2'b00, 6);

    // Long threshold, lowered mid-check: accepted on the next high sample.
    bus.debounce_cycles_i = 8'd200;
    hold(2'b11, 50);
    bus.debounce_cycles_i = 8'd10;
    hold(2'b11, 4);
    hold(2'b00, 14);

    // Asynchronous reset while channel 0 is mid-check.
    bus.debounce_cycles_i = 8'd4;
    hold(2'b01, 4);
    rst_n = 1'b0;
    hold(2'b00, 2);
    rst_n = 1'b1;
    hold(2'b00, 8);

`ifdef GPIO_IN_GLITCH_CNT_EN
    // 300 glitches saturate the counter at 255.
    for (int k = 0; k < 300; k++) begin
      hold(2'b01, 2);
      hold(2'b00, 2);
    end
    hold(2'b00, 4);
    // Clear held across a glitch abort wins over the increment.
    clr = 1'b1;
    hold(2'b01, 2);
    hold(2'b00, 3);
    clr = 1'b0;
    hold(2'b00, 4);
`endif

    // Random segments: thresholds, enables, pin activity and clears all vary.
    for (int seg = 0; seg < 40; seg++) begin
      logic [G-1:0] g;
      g = bus.gpio_i;
      bus.filt_en_i = G'($urandom_range((1 << G) - 1));
      bus.debounce_cycles_i = CW'($urandom_range(6));
      for (int k = 0; k < 40; k++) begin
        for (int i = 0; i < G; i++)
          if ($urandom_range(3) == 0) g[i] = ~g[i];
        if ($urandom_range(15) == 0) bus.debounce_cycles_i = CW'($urandom_range(6));
        if ($urandom_range(31) == 0) bus.filt_en_i[$urandom_range(G - 1)] ^= 1'b1;
        clr = ($urandom_range(49) == 0);
        hold(g, 1 + $urandom_range(5));
      end
    end
    clr = 1'b0;
    hold('0, 12);

    started = 1'b0;
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Per-pin input conditioning stage in front of the GPIO core's `gpio_data_i`.
- Each channel gets a multi-flop synchronizer, then a programmable-length debounce FSM.
- Outputs a clean level plus registered one-cycle rise and fall pulses per channel.
- Lets the core see only metastability-safe, glitch-free levels; the pulses are available for wake-up and event logic.

Parameters:
- GPIO_NUM, 2, number of channels (1..8).
- SYNC_STAGES, 2, synchronizer depth (>=2).
- CNT_W, 8, debounce counter / threshold width.

Ports:
- clk_i  input  1  clock; all flops on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- gpio_i  input  GPIO_NUM  raw asynchronous pad inputs.
- filt_en_i  input  GPIO_NUM  per-channel debounce enable (quasi-static).
- debounce_cycles_i  input  CNT_W  stable-sample threshold N, shared by all channels.
- gpio_o  output  GPIO_NUM  conditioned level, connects to the core's `gpio_data_i`.
- rise_o  output  GPIO_NUM  one-cycle pulse on accepted 0->1.
- fall_o  output  GPIO_NUM  one-cycle pulse on accepted 1->0.

Behaviour:
- Reset (async assert, sync-to-clock deassert done externally):
  - all sync flops 0;
  - every FSM in STABLE_LO with cnt=0;
  - gpio_o=0, rise_o=0, fall_o=0.
- Synchronizer: SYNC_STAGES flops per channel. `s` denotes the last stage output.
- Effective threshold Neff = (debounce_cycles_i==0) ? 1 : debounce_cycles_i. The threshold is read live every cycle and is not latched.
- FSM states per channel: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO, s=0: stay.
  - STABLE_LO, s=1: if Neff==1, go to STABLE_HI; else go to CHK_HI with cnt=1.
  - CHK_HI, s=0: glitch; go to STABLE_LO, cnt=0, no pulse.
  - CHK_HI, s=1: if cnt+1>=Neff, go to STABLE_HI and clear cnt; else cnt++ (saturating at 2^CNT_W-1).
  - STABLE_HI and CHK_LO: mirror image of the above, with 0/1 swapped.
- gpio_o is registered and equals 1 exactly when the state is STABLE_HI or CHK_LO.
  - rise_o is high for exactly the first cycle gpio_o is 1.
  - fall_o is high for exactly the first cycle gpio_o is 0.
  - rise_o and fall_o are never both high.
- Latency: pin steady at the new level from before edge k → gpio_o changes after edge k+SYNC_STAGES+Neff-1.
- Threshold lowered mid-check: if cnt+1 is already >= the new Neff, the FSM accepts on the next sample of the new level.
- filt_en_i[i]=0 (bypass):
  - next state = s ? STABLE_HI : STABLE_LO, cnt cleared;
  - gpio_o follows s with 1-cycle register latency;
  - pulses are still generated on each change.
- filt_en_i toggling mid-check: enable 1->0 resolves immediately to s. Enable 0->1 starts from the current stable state. No spurious pulse in either case unless gpio_o actually changes.
- Asynchronous reset mid-check clears everything; no pulse is emitted on reset release.

Optional Feature:
- Macro: GPIO_IN_GLITCH_CNT_EN.
- Defined:
  - adds output port glitch_cnt_o, GPIO_NUM*8 bits, one 8-bit counter per channel at [i*8+7:i*8];
  - a counter increments on every CHK_HI->STABLE_LO or CHK_LO->STABLE_HI abort;
  - counters saturate at 255 and reset to 0;
  - input glitch_clr_i (1 bit) synchronously clears all counters, and has priority over a same-cycle increment.
- Not defined: neither port exists, and no counter logic is present.

Test Plan:
1. Reset, then all inputs 0 → gpio_o=0, no pulses for 100 cycles. Assert rst_ni=0 while in CHK_HI → gpio_o=0, state STABLE_LO, no pulse after release.
2. debounce_cycles_i=4, filt_en_i=1, gpio_i[0] 0->1 held → gpio_o[0]=1 exactly SYNC_STAGES+3 edges after the first sampling edge; rise_o[0] high 1 cycle; gpio_o[1] unchanged.
3. debounce_cycles_i=4, gpio_i[0] high for 3 cycles then low → gpio_o stays 0, no pulses. With GPIO_IN_GLITCH_CNT_EN, glitch_cnt_o[7:0]=1.
4. filt_en_i=0, 1-cycle-wide high pulse on gpio_i[1] → gpio_o[1] high for exactly 1 cycle; rise_o and fall_o pulse on consecutive cycles.
5. debounce_cycles_i=0 vs 1 → identical latency, SYNC_STAGES edges. debounce_cycles_i=200 held, then reduced to 10 while cnt=50 → accepted on the next high sample.
6. With GPIO_IN_GLITCH_CNT_EN: 300 glitches → count saturates at 255. glitch_clr_i asserted together with a glitch → count 0.
